// File: rtl/tile_out_logger_pkg.sv
// Shared types for the tile output logger.
// Event entry layout and UART transmitter states.
package tile_out_logger_pkg;

  localparam int DATA_BITS = 8;
  localparam int TS_W      = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] value;
    logic [TS_W-1:0]      ts;
  } entry_t;

endpackage

// File: rtl/log_fifo.sv
// Small synchronous FIFO for logged events.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module log_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tile_out_logger.sv
// Timestamps every change of the microtile output bus and
// streams {value, ts} byte pairs out as 8N1 UART frames.
module tile_out_logger
  import tile_out_logger_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tile_out,
  input  logic       enable,
  input  logic       clr_ovf,
  output logic       tx,
  output logic       busy,
  output logic       overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  logic [7:0]      sync1, sync2, last_logged;
  logic [TS_W-1:0] ts_cnt;
  logic            detect, pop, full, empty;
  entry_t          head, cur, cur_n;
  logic [$clog2(FIFO_DEPTH):0] count;

  tx_state_t       state, state_n;
  logic [CW-1:0]   clk_cnt, clk_cnt_n;
  logic [BW-1:0]   bit_cnt, bit_cnt_n;
  logic            byte_sel, byte_sel_n;
  logic            bit_done;

  assign detect = enable && (sync2 != last_logged);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1       <= '0;
      sync2       <= '0;
      last_logged <= '0;
      ts_cnt      <= '0;
      overflow    <= 1'b0;
    end else begin
      sync1  <= tile_out;
      sync2  <= sync1;
      ts_cnt <= ts_cnt + TS_W'(1);
      if (detect) last_logged <= sync2;
      // a drop in the same cycle as a clear keeps the flag set
      if (detect && full && !pop) overflow <= 1'b1;
      else if (clr_ovf)           overflow <= 1'b0;
    end
  end

  log_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (detect),
    .pop   (pop),
    .wdata ({sync2, ts_cnt}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      byte_sel <= 1'b0;
      cur      <= '0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_cnt  <= bit_cnt_n;
      byte_sel <= byte_sel_n;
      cur      <= cur_n;
    end
  end

  assign bit_done = (clk_cnt == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_n    = state;
    clk_cnt_n  = clk_cnt;
    bit_cnt_n  = bit_cnt;
    byte_sel_n = byte_sel;
    cur_n      = cur;
    pop        = 1'b0;
    if (state != IDLE)
      clk_cnt_n = bit_done ? '0 : clk_cnt + CW'(1);
    unique case (state)
      IDLE: begin
        // entry stays in the FIFO until both bytes are out
        if (!empty) begin
          cur_n      = head;
          byte_sel_n = 1'b0;
          clk_cnt_n  = '0;
          state_n    = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_n = bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_BITS - 1))
            state_n = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!byte_sel) begin
            byte_sel_n = 1'b1;
            state_n    = START;
          end else begin
            pop     = 1'b1;
            state_n = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = byte_sel ? cur.ts[bit_cnt]
                             : cur.value[bit_cnt];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_tile_out_logger.sv
// Randomized scoreboard bench for tile_out_logger.
// A cycle-level event model predicts bytes; a UART decoder checks them.
module tb_tile_out_logger;

  localparam int C = 4;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tile_out;
  logic       enable;
  logic       clr_ovf;
  logic       tx;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  tile_out_logger #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tile_out (tile_out),
    .enable   (enable),
    .clr_ovf  (clr_ovf),
    .tx       (tx),
    .busy     (busy),
    .overflow (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events, FIFO occupancy and drops as whole-event quantities.
  logic [15:0] mq[$];
  logic [7:0]  exp_q[$];
  int          cyc;
  logic [7:0]  t1, t2, last;
  bit          m_ovf, m_tx, m_pop, m_set;
  int          pop_edge;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      cyc = 0; t1 = 0; t2 = 0; last = 0;
      m_ovf = 0; m_tx = 0; pop_edge = 0;
    end else begin
      m_pop = m_tx && (pop_edge == cyc + 1);
      m_set = 0;
      // logger sees tile_out two cycles late; ts is this cycle's count
      if (enable && t2 != last) begin
        last = t2;
        if (mq.size() < D || m_pop) begin
          mq.push_back({t2, cyc[7:0]});
          exp_q.push_back(t2);
          exp_q.push_back(cyc[7:0]);
        end else m_set = 1;
      end
      if (m_pop) begin
        void'(mq.pop_front());
        m_tx = 0;
      end
      if (m_set) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      t2 = t1;
      t1 = tile_out;
      cyc++;
      // one latch cycle then two 10-bit frames
      if (!m_tx && mq.size() != 0) begin
        m_tx = 1;
        pop_edge = cyc + 1 + 20 * C;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", busy, mq.size() != 0);
      check("overflow", overflow, m_ovf);
    end
  end

  // UART decoder / scoreboard monitor
  int         mt;
  bit         mact = 0;
  logic [7:0] mb;
  logic [7:0] rx_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      mact = 0;
      check("tx_in_reset", tx, 1);
    end else if (!mact) begin
      if (tx == 1'b0) begin
        mact = 1;
        mt = 0;
      end
    end else begin
      mt++;
      if (mt == C / 2)
        check("start_bit", tx, 0);
      else if (mt >= C + C / 2 && mt < 9 * C + C / 2 && (mt - C / 2) % C == 0)
        mb[(mt - C / 2) / C - 1] = tx;
      else if (mt == 9 * C + C / 2) begin
        check("stop_bit", tx, 1);
        rx_log.push_back(mb);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none", mb);
        end else
          check("tx_byte", mb, exp_q.pop_front());
        mact = 0;
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(string name, int maxc);
    int k = 0;
    step(4);
    while ((busy || exp_q.size() != 0 || mact) && k < maxc) begin
      step();
      k++;
    end
    check({name, "_timeout"}, k < maxc, 1);
  endtask

  int base;
  int k;

  initial begin
    tile_out = 8'h3C;
    enable   = 1'b0;
    clr_ovf  = 1'b0;
    step(3);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ovf", overflow, 0);
    rst_n = 1'b1;
    step(100);
    check("disabled_no_frame", rx_log.size(), 0);

    // single event 0x00 -> 0xA5
    tile_out = 8'h00;
    step(3);
    enable = 1'b1;
    step(3);
    base = rx_log.size();
    tile_out = 8'hA5;
    wait_idle("single", 300);
    check("single_count", rx_log.size() - base, 2);
    if (rx_log.size() >= base + 2) check("single_value", rx_log[base], 8'hA5);

    // overflow: six rapid changes into a four-deep FIFO
    base = rx_log.size();
    for (int i = 1; i <= 6; i++) begin
      tile_out = 8'(i);
      step(2);
    end
    step(3);
    check("ovf_set", overflow, 1);
    tile_out = 8'h07;
    step(2);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_set_wins", overflow, 1);
    step(5);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    wait_idle("overflow", 600);
    check("ovf_count", rx_log.size() - base, 8);
    for (int i = 0; i < 4; i++)
      if (rx_log.size() >= base + 8)
        check("ovf_order", rx_log[base + 2 * i], 8'(i + 1));

    // timestamp wrap: captures at counter 0xFF and 0x00
    base = rx_log.size();
    while ((cyc & 255) != 253) step();
    tile_out = 8'h55;
    step();
    tile_out = 8'hAA;
    wait_idle("wrap", 400);
    check("wrap_count", rx_log.size() - base, 4);
    if (rx_log.size() >= base + 4) begin
      check("wrap_ts_ff", rx_log[base + 1], 8'hFF);
      check("wrap_ts_00", rx_log[base + 3], 8'h00);
    end

    // changes while disabled collapse into one event
    base = rx_log.size();
    enable = 1'b0;
    tile_out = 8'h10; step(3);
    tile_out = 8'h20; step(3);
    tile_out = 8'h30; step(3);
    enable = 1'b1;
    wait_idle("disable", 300);
    check("disable_count", rx_log.size() - base, 2);
    if (rx_log.size() >= base + 2) check("disable_value", rx_log[base], 8'h30);

    // randomized traffic
    for (int i = 0; i < 250; i++) begin
      tile_out = 8'($urandom);
      enable   = ($urandom_range(0, 3) != 0);
      clr_ovf  = ($urandom_range(0, 15) == 0);
      step($urandom_range(1, 12));
    end
    clr_ovf = 1'b0;
    enable  = 1'b1;
    wait_idle("random", 3000);

    // reset in the middle of a data bit
    tile_out = ~tile_out;
    k = 0;
    while (!(mact && mt >= 2 * C) && k < 200) begin
      step();
      k++;
    end
    check("midframe_reached", k < 200, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_tx", tx, 1);
    check("midreset_busy", busy, 0);
    enable = 1'b0;
    step(3);
    rst_n = 1'b1;
    base = rx_log.size();
    step(150);
    check("no_residual_frame", rx_log.size() - base, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_out_logger.md
Name: tile_out_logger

Overview:
- Downstream monitor for a Wokwi microtile: consumes the tile's 8-bit uo_out bus, here named tile_out.
- Detects every change of tile_out and timestamps it.
- Buffers events in a small FIFO and streams them off-chip as 8N1 UART frames on one pin.
- Used on the bench and on silicon to observe tile behaviour without an 8-pin scope.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit (legal: ≥2).
- FIFO_DEPTH, 4, event entries; power of two, ≥2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- tile_out  in  8  microtile output bus (uo_out); asynchronous to clk.
- enable  in  1  1 = detect and log changes.
- clr_ovf  in  1  synchronous clear of the overflow flag.
- tx  out  1  UART serial output; idle high.
- busy  out  1  FIFO non-empty or transmitter active.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_n=0) forces:
  - tx=1, busy=0, overflow=0.
  - Sync flops=0, last_logged=0, timestamp counter=0.
  - FIFO empty; FSM in IDLE.
  - Reset mid-frame aborts the frame; tx returns high immediately.
- Input sampling:
  - Two-flop synchronizer sync1→sync2 on tile_out.
- Timestamp:
  - 8-bit free-running cycle counter, +1 every clk, wraps 255→0.
- Change detect, evaluated each cycle when enable=1:
  - Condition: sync2 != last_logged.
  - Action: push {value=sync2, ts=counter} and set last_logged=sync2.
  - last_logged updates even when the push is dropped.
- Push latency:
  - tile_out changes before edge N → sync1 at N, sync2 at N+1.
  - Entry is written at edge N+2, carrying ts = counter value at N+1.
- First event after reset:
  - last_logged=0, so a nonzero tile_out produces an event once enable=1.
- enable=0:
  - No detection; last_logged frozen.
  - A change made while disabled produces exactly one event (current value) on re-enable.
  - Transmission and FIFO drain continue.
- FIFO:
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the event is dropped and overflow is set.
  - clr_ovf=1 clears overflow; a set in the same cycle wins (overflow stays 1).
- TX FSM states: IDLE, START, DATA, STOP. Each state holds each bit for CLKS_PER_BIT cycles.
  - IDLE: tx=1. When FIFO non-empty, latch the head entry (no pop), set byte_sel=0, go START next cycle.
  - START: tx=0.
  - DATA: 8 bits, LSB first. byte_sel=0 sends value; byte_sel=1 sends ts.
  - STOP: tx=1 for one bit time. Then:
    - byte_sel=0 → set byte_sel=1, go START.
    - byte_sel=1 → pop FIFO, go IDLE.
  - One event = 20·CLKS_PER_BIT cycles. Back-to-back events add exactly 1 IDLE cycle between frames.
- busy:
  - busy = (state!=IDLE) | (count!=0). It is a registered-state function, so it has no combinational path from the inputs.

Decomposition:
- Package tile_out_logger_pkg:
  - tx state enum (IDLE, START, DATA, STOP).
  - Entry struct {value[7:0], ts[7:0]}.
  - Constants DATA_BITS=8, TS_W=8.
- Sub-module log_fifo:
  - Synchronous FIFO parameterised by depth and width.
  - Push, pop, full, empty and count outputs.
  - Simultaneous push/pop on full is allowed.
- Synchronizer, change detect, timestamp counter and TX FSM live in the top module.

Test Plan:
- Reset: hold rst_n=0 with tile_out=0x3C → tx=1, busy=0, overflow=0. Release with enable=0 → no frame for 100 cycles.
- Single event: CLKS_PER_BIT=4, enable=1, tile_out 0x00→0xA5 → FIFO entry written 2 edges later. tx then shows start, bits 1,0,1,0,0,1,0,1, stop, then the ts byte (counter at sync2 capture); each bit is 4 cycles, 80 cycles total.
- Overflow: FIFO_DEPTH=4, long CLKS_PER_BIT, 6 rapid changes (0x01..0x06) → first 4 events sent in order, overflow=1. clr_ovf pulse together with a 7th dropped change → overflow stays 1; a later isolated clr_ovf clears it.
- Timestamp wrap: two changes placed so the captures straddle counter 255→0 → transmitted ts bytes are 0xFF and 0x00.
- Disable: enable=0, tile_out toggles 0x10→0x20→0x30, then enable=1 → exactly one event with value 0x30.
- Reset mid-frame: assert rst_n during DATA of a frame → tx=1 within the same cycle (async), busy=0. After release, no residual frame is emitted.
